// File: rtl/sdf_pkg.sv
// sdf_pkg: shared state type and default sizing for the SDF FFT frame controller.
package sdf_pkg;
    typedef enum logic [1:0] {IDLE, RUN, WAIT, FLUSH} state_t;
    localparam int SDF_WIDTH     = 8;
    localparam int SDF_N         = 16;
    localparam int SDF_LOG2N     = 4;
    localparam int SDF_TAG_DEPTH = 4;
endpackage

// File: rtl/frame_tag_fifo.sv
// frame_tag_fifo: 1-bit tag FIFO marking each in-flight frame as real (1) or dummy (0).
module frame_tag_fifo import sdf_pkg::*; #(
    parameter int DEPTH = SDF_TAG_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic do_push, do_pop;
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign dout    = mem[rp];
    assign do_pop  = pop && !empty;
    // a pop frees the slot in the same cycle, so a full FIFO may still take a push
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
            end
            if (do_pop)
                rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sdf_frame_ctrl.sv
// sdf_frame_ctrl: admits N-point frames into the SDF pipeline, flushes with a dummy frame
// when the source idles, and strips dummy samples from the tagged output stream.
module sdf_frame_ctrl import sdf_pkg::*; #(
    parameter int WIDTH     = SDF_WIDTH,
    parameter int N         = SDF_N,
    parameter int LOG2N     = SDF_LOG2N,
    parameter int IDLE_WAIT = 4,
    parameter int TAG_DEPTH = SDF_TAG_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_re,
    input  logic [WIDTH-1:0] s_im,
    output logic             fft_en,
    output logic [WIDTH-1:0] fft_re,
    output logic [WIDTH-1:0] fft_im,
    output logic [LOG2N-1:0] fft_cnt,
    input  logic             fft_en_out,
    input  logic [WIDTH-1:0] fft_out_re,
    input  logic [WIDTH-1:0] fft_out_im,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_re,
    output logic [WIDTH-1:0] m_im,
    output logic [LOG2N-1:0] m_idx,
    output logic             m_last,
    output logic             frame_done,
    output logic             busy,
    output logic             tag_err
);
    localparam int IW = $clog2(IDLE_WAIT + 1);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    state_t state;
    logic [LOG2N-1:0] in_cnt, flush_cnt, out_cnt;
    logic [IW-1:0] idle_cnt;
    logic accept, push, pop, full, empty, head, real_head, done_pend;
    assign s_ready   = state != FLUSH && !full;
    assign accept    = s_valid && s_ready;
    assign push      = (accept && in_cnt == '0) || (state == FLUSH && flush_cnt == '0);
    assign pop       = fft_en_out && out_cnt == LAST;
    assign real_head = !empty && head;
    assign busy      = state != IDLE || !empty;

    frame_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (accept),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_cnt    <= '0;
            flush_cnt <= '0;
            idle_cnt  <= '0;
            fft_en    <= 1'b0;
            fft_re    <= '0;
            fft_im    <= '0;
            fft_cnt   <= '0;
        end else begin
            fft_en <= accept || state == FLUSH;
            if (accept) begin
                fft_re  <= s_re;
                fft_im  <= s_im;
                fft_cnt <= in_cnt;
                in_cnt  <= in_cnt + LOG2N'(1);
            end else if (state == FLUSH) begin
                fft_re    <= '0;
                fft_im    <= '0;
                fft_cnt   <= flush_cnt;
                flush_cnt <= flush_cnt + LOG2N'(1);
            end
            case (state)
                IDLE: if (accept) state <= RUN;
                RUN: if (accept && in_cnt == LAST) begin
                    state    <= WAIT;
                    idle_cnt <= '0;
                end
                // the flush waits for a free tag slot so its dummy tag is never lost
                WAIT: if (accept) state <= RUN;
                      else if (idle_cnt == IW'(IDLE_WAIT)) state <= full ? WAIT : FLUSH;
                      else idle_cnt <= idle_cnt + IW'(1);
                FLUSH: if (flush_cnt == LAST) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt    <= '0;
            m_valid    <= 1'b0;
            m_re       <= '0;
            m_im       <= '0;
            m_idx      <= '0;
            m_last     <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
            tag_err    <= 1'b0;
        end else begin
            m_valid    <= fft_en_out && real_head;
            m_last     <= fft_en_out && real_head && out_cnt == LAST;
            done_pend  <= pop && real_head;
            frame_done <= done_pend;
            tag_err    <= tag_err || (pop && empty);
            if (fft_en_out) begin
                m_re    <= fft_out_re;
                m_im    <= fft_out_im;
                m_idx   <= out_cnt;
                out_cnt <= out_cnt + LOG2N'(1);
            end
        end
    end
endmodule

// File: tb/tb_sdf_frame_ctrl.sv
// tb_sdf_frame_ctrl: directed bench with the datapath modelled as a zero-latency loopback,
// so every output sample can be matched against the input pattern by index.
module tb_sdf_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_re = '0, s_im = '0;
    logic       fft_en;
    logic [7:0] fft_re, fft_im;
    logic [3:0] fft_cnt;
    logic       fft_en_out;
    logic       m_valid, m_last, frame_done, busy, tag_err;
    logic [7:0] m_re, m_im;
    logic [3:0] m_idx;
    logic       force_mode = 1'b0, force_en = 1'b0;
    int tests = 0, fails = 0;
    int mv_cnt = 0, done_cnt = 0, en_cnt = 0, mon_err = 0, mon_idx = 0;
    int s_mv, s_done, s_en;

    always #5 clk = ~clk;
    assign fft_en_out = force_mode ? force_en : fft_en;

    sdf_frame_ctrl #(.WIDTH(8), .N(16), .LOG2N(4), .IDLE_WAIT(4), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .fft_en(fft_en), .fft_re(fft_re), .fft_im(fft_im), .fft_cnt(fft_cnt),
        .fft_en_out(fft_en_out), .fft_out_re(fft_re), .fft_out_im(fft_im),
        .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_idx(m_idx), .m_last(m_last),
        .frame_done(frame_done), .busy(busy), .tag_err(tag_err)
    );

    function automatic logic [7:0] f_re(input int i);
        return i < 8 ? 8'(2 * i) : 8'(-i);
    endfunction
    function automatic logic [7:0] f_im(input int i);
        return i < 8 ? 8'(-i) : 8'(i);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) mon_idx = 0;
        else begin
            en_cnt   += int'(fft_en);
            done_cnt += int'(frame_done);
            if (m_valid) begin
                if (m_idx !== 4'(mon_idx) || m_re !== f_re(mon_idx) || m_im !== f_im(mon_idx)
                    || m_last !== (mon_idx == 15)) mon_err++;
                mon_idx = (mon_idx + 1) % 16;
                mv_cnt++;
            end else if (m_last) mon_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        #2;
        s_mv = mv_cnt; s_done = done_cnt; s_en = en_cnt;
    endtask

    task automatic deltas(input string tag, input int mv, input int dn, input int en);
        #2;
        chk({tag, "_mvalid"}, mv_cnt - s_mv, mv);
        chk({tag, "_done"}, done_cnt - s_done, dn);
        chk({tag, "_fft_en"}, en_cnt - s_en, en);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic send_frame(input int gap_after, input int gap_len);
        for (int i = 0; i < 16; i++) begin
            chk("s_ready", s_ready, 1);
            s_valid = 1'b1; s_re = f_re(i); s_im = f_im(i);
            @(negedge clk);
            chk($sformatf("fft_in[%0d]", i), {fft_en, fft_cnt, fft_re, fft_im}, {1'b1, 4'(i), f_re(i), f_im(i)});
            if (i == gap_after) begin
                s_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("bubble", {fft_en, fft_re, fft_im}, {1'b0, f_re(i), f_im(i)});
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic check_flush();
        int w, len;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("wait_ready[%0d]", k), s_ready, 1);
        end
        w = 0;
        while (s_ready === 1'b1 && w < 4) begin @(negedge clk); w++; end
        chk("flush_start", s_ready, 0);
        len = 0;
        while (s_ready === 1'b0 && len < 40) begin @(negedge clk); len++; end
        chk("flush_len", len, 16);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {fft_en, fft_cnt, fft_re, fft_im, m_valid, m_idx, m_re, m_im, m_last, frame_done, busy, tag_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {s_ready, busy}, 2'b10);

        snap();
        send_frame(-1, 0);
        check_flush();
        deltas("single", 16, 1, 32);

        snap();
        send_frame(-1, 0);
        send_frame(-1, 0);
        check_flush();
        deltas("b2b", 32, 2, 48);

        snap();
        send_frame(7, 3);
        check_flush();
        deltas("bubble", 16, 1, 32);

        snap();
        send_frame(-1, 0);
        repeat (2) begin
            @(negedge clk);
            chk("wait_rearm_ready", s_ready, 1);
        end
        send_frame(-1, 0);
        check_flush();
        deltas("rearm", 32, 2, 48);

        snap();
        force_mode = 1'b1; force_en = 1'b1;
        repeat (16) @(negedge clk);
        force_en = 1'b0; force_mode = 1'b0;
        chk("tag_err_set", tag_err, 1);
        repeat (5) @(negedge clk);
        chk("tag_err_sticky", tag_err, 1);
        deltas("forced", 0, 0, 0);

        snap();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_re = f_re(i); s_im = f_im(i);
            @(negedge clk);
        end
        chk("partial_busy", busy, 1);
        rst_n = 1'b0; s_valid = 1'b0;
        #1;
        chk("midrun_reset", {fft_en, fft_cnt, fft_re, fft_im, m_valid, m_idx, m_re, m_im, m_last, frame_done, busy, tag_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_ready", s_ready, 1);
        #2;
        chk("partial_no_done", done_cnt - s_done, 0);
        snap();
        send_frame(-1, 0);
        check_flush();
        deltas("post_reset", 16, 1, 32);
        chk("monitor", mon_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
